// File: rtl/bram_pkg.sv
// Shared types and helpers for the masked dual-port block RAM and its clear sequencer.
package bram_pkg;

   typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

   localparam int MAX_DATA_W = 64;

   // A mask bit of 1 keeps the old bit; callers truncate to their own word width.
   function automatic logic [MAX_DATA_W-1:0] apply_mask(input logic [MAX_DATA_W-1:0] old_word,
                                                        input logic [MAX_DATA_W-1:0] new_word,
                                                        input logic [MAX_DATA_W-1:0] mask_word);
      return (old_word & mask_word) | (new_word & ~mask_word);
   endfunction

   function automatic bit depth_fits(input int depth, input int addr_w);
      return (addr_w >= 1) && (addr_w <= 30) && (depth >= 1) && (depth <= (1 << addr_w));
   endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Clear sequencer: walks every word once, driving a dedicated write port with the fill value.
module bram_clear_seq
   import bram_pkg::*;
#(
   parameter int DEPTH          = 256,
   parameter int ADDR_W         = 8,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_start,
   output logic              init_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W:0] LAST_ADDR   = (ADDR_W+1)'(DEPTH - 1);
   localparam clr_state_e      RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;

   clr_state_e      state;
   clr_state_e      state_nxt;
   logic [ADDR_W:0] cnt;
   logic [ADDR_W:0] cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_STATE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The extra counter bit keeps the last-address compare safe when DEPTH fills the address space.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLR_IDLE: begin
            if (init_start) begin
               state_nxt = CLR_RUN;
               cnt_nxt   = '0;
            end
         end
         CLR_RUN: begin
            if (cnt == LAST_ADDR) begin
               state_nxt = CLR_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + (ADDR_W+1)'(1);
            end
         end
         default: begin
            state_nxt = CLR_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign init_busy = (state == CLR_RUN);
   assign clr_we    = (state == CLR_RUN);
   assign clr_addr  = cnt[ADDR_W-1:0];

endmodule

// File: rtl/bram_masked_dp.sv
// Simple dual-port RAM with per-bit write mask, optional output register,
// selectable read-during-write result and a built-in clear sequencer.
module bram_masked_dp
   import bram_pkg::*;
#(
   parameter int                DATA_W         = 16,
   parameter int                DEPTH          = 256,
   parameter int                ADDR_W         = 8,
   parameter int                OUT_REG        = 0,
   parameter int                RDW_MODE       = 0,
   parameter int                CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wclke,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mask,
   input  logic              rclke,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              init_start,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              init_busy
);

   if (!depth_fits(DEPTH, ADDR_W) || (DATA_W < 1) || (DATA_W > MAX_DATA_W)) begin : g_bad_cfg
      $error("bram_masked_dp: illegal DATA_W/DEPTH/ADDR_W combination");
   end

   localparam bit              RDW_IS_NEW = (RDW_MODE == int'(RDW_NEW));
   localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_fire;
   logic              rd_fire;
   logic              wr_in_range;
   logic              rd_in_range;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_data_s1;
   logic              rd_valid_s1;

   bram_clear_seq #(
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .init_busy  (init_busy),
      .clr_we     (clr_we),
      .clr_addr   (clr_addr)
   );

   assign wr_fire     = wclke & we & ~init_busy;
   assign rd_fire     = rclke & re & ~init_busy;
   assign wr_in_range = ({1'b0, waddr} < DEPTH_C);
   assign rd_in_range = ({1'b0, raddr} < DEPTH_C);
   assign merged      = DATA_W'(apply_mask(MAX_DATA_W'(mem[waddr]), MAX_DATA_W'(wdata),
                                           MAX_DATA_W'(mask)));

   // The clear port owns the array while busy, so user writes never collide with it.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= CLEAR_VALUE;
      end else if (wr_fire && wr_in_range) begin
         mem[waddr] <= merged;
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         if (RDW_IS_NEW && wr_fire && wr_in_range && (waddr == raddr)) begin
            rd_word = merged;
         end else begin
            rd_word = mem[raddr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_s1  <= '0;
         rd_valid_s1 <= 1'b0;
      end else begin
         rd_valid_s1 <= rd_fire;
         if (rd_fire) begin
            rd_data_s1 <= rd_word;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rd_data_s2;
      logic              rd_valid_s2;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_s2  <= '0;
            rd_valid_s2 <= 1'b0;
         end else begin
            rd_valid_s2 <= rd_valid_s1;
            if (rd_valid_s1) begin
               rd_data_s2 <= rd_data_s1;
            end
         end
      end

      assign rdata  = rd_data_s2;
      assign rvalid = rd_valid_s2;
   end else begin : g_no_out_reg
      assign rdata  = rd_data_s1;
      assign rvalid = rd_valid_s1;
   end

endmodule

// File: tb/tb_bram_masked_dp.sv
// Drives two RAM configurations from shared stimulus and scores each read strobe against a queue.
module tb_bram_masked_dp;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wclke = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  waddr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] mask = '0;
   logic        rclke = 1'b0;
   logic        re = 1'b0;
   logic [7:0]  raddr = '0;
   logic        init_start = 1'b0;
   logic [15:0] rdata_a, rdata_b;
   logic        rvalid_a, rvalid_b;
   logic        busy_a, busy_b;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];
   exp_t        e_a, e_b;
   logic [15:0] model_a [256];
   logic [15:0] model_b [200];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: full depth, old-data RDW, no output register.
   bram_masked_dp #(
      .DATA_W(16), .DEPTH(256), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(0),
      .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .wclke(wclke), .we(we), .waddr(waddr), .wdata(wdata),
      .mask(mask), .rclke(rclke), .re(re), .raddr(raddr), .init_start(init_start),
      .rdata(rdata_a), .rvalid(rvalid_a), .init_busy(busy_a)
   );

   // Instance B: partial depth, new-data RDW, output register.
   bram_masked_dp #(
      .DATA_W(16), .DEPTH(200), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(1),
      .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .wclke(wclke), .we(we), .waddr(waddr), .wdata(wdata),
      .mask(mask), .rclke(rclke), .re(re), .raddr(raddr), .init_start(init_start),
      .rdata(rdata_b), .rvalid(rvalid_b), .init_busy(busy_b)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_read(input logic [7:0] a, input bit same_wr,
                            input logic [15:0] wd, input logic [15:0] wm);
      exp_t ea, eb;
      ea.data = model_a[a];
      ea.cyc  = cyc + 1;
      if (a >= 8'd200)  eb.data = 16'h0000;
      else if (same_wr) eb.data = (model_b[a] & wm) | (wd & ~wm);
      else              eb.data = model_b[a];
      eb.cyc = cyc + 2;
      q_a.push_back(ea);
      q_b.push_back(eb);
   endtask

   task automatic model_write(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
      model_a[a] = (model_a[a] & m) | (d & ~m);
      if (a < 8'd200) model_b[a] = (model_b[a] & m) | (d & ~m);
   endtask

   task automatic apply_read(input logic [7:0] a);
      rclke = 1'b1; re = 1'b1; raddr = a;
      push_read(a, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      rclke = 1'b0; re = 1'b0;
   endtask

   task automatic apply_write(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
      wclke = 1'b1; we = 1'b1; waddr = a; wdata = d; mask = m;
      model_write(a, d, m);
      @(negedge clk);
      wclke = 1'b0; we = 1'b0;
   endtask

   task automatic apply_rw(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
      wclke = 1'b1; we = 1'b1; waddr = a; wdata = d; mask = m;
      rclke = 1'b1; re = 1'b1; raddr = a;
      push_read(a, 1'b1, d, m);
      model_write(a, d, m);
      @(negedge clk);
      wclke = 1'b0; we = 1'b0; rclke = 1'b0; re = 1'b0;
   endtask

   // Counts busy cycles of both instances; optionally pokes writes, reads and init_start meanwhile.
   task automatic measure_clear(input string tag, input bit noise);
      int na = 0;
      int nb = 0;
      int n = 0;
      while ((busy_a || busy_b) && n < 600) begin
         if (busy_a) na++;
         if (busy_b) nb++;
         if (noise) begin
            we = (n < 190) && (n % 3 == 0);
            wclke = we;
            waddr = 8'(n);
            wdata = 16'hFFFF;
            mask = 16'h0000;
            re = (n < 190) && (n % 5 == 0);
            rclke = re;
            raddr = 8'(n);
            init_start = (n == 50);
         end
         n++;
         @(negedge clk);
      end
      we = 1'b0; wclke = 1'b0; re = 1'b0; rclke = 1'b0; init_start = 1'b0;
      check_output({tag, "_busy_a"}, na, 256);
      check_output({tag, "_busy_b"}, nb, 200);
      for (int i = 0; i < 256; i++) model_a[i] = 16'hA5A5;
      for (int i = 0; i < 200; i++) model_b[i] = 16'h0000;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid_a) begin
            if (q_a.size() == 0) begin
               check_output("a_unexpected_rvalid", rvalid_a, 1'b0);
            end else begin
               e_a = q_a.pop_front();
               check_output("a_rdata", rdata_a, e_a.data);
               check_output("a_latency", cyc, e_a.cyc);
            end
         end
         if (rvalid_b) begin
            if (q_b.size() == 0) begin
               check_output("b_unexpected_rvalid", rvalid_b, 1'b0);
            end else begin
               e_b = q_b.pop_front();
               check_output("b_rdata", rdata_b, e_b.data);
               check_output("b_latency", cyc, e_b.cyc);
            end
         end
      end
   end

   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clk);
      check_output("rst_rdata_a", rdata_a, 16'h0);
      check_output("rst_rvalid_a", rvalid_a, 1'b0);
      check_output("rst_busy_a", busy_a, 1'b1);
      check_output("rst_rdata_b", rdata_b, 16'h0);
      check_output("rst_rvalid_b", rvalid_b, 1'b0);
      check_output("rst_busy_b", busy_b, 1'b1);

      rst_n = 1'b1;
      measure_clear("boot", 1'b0);
      apply_read(8'h00);
      apply_read(8'hFF);
      apply_write(8'h10, 16'h1234, 16'hFF00);
      apply_read(8'h10);

      apply_write(8'h20, 16'h0000, 16'h0000);
      apply_rw(8'h20, 16'hBEEF, 16'h0000);
      apply_read(8'h20);

      apply_write(8'hC8, 16'h1111, 16'h0000);
      apply_write(8'hC7, 16'h5A5A, 16'h0000);
      apply_read(8'hC8);
      apply_read(8'hC7);
      repeat (3) @(negedge clk);
      check_output("hold_rdata_a", rdata_a, 16'h5A5A);
      check_output("hold_rdata_b", rdata_b, 16'h5A5A);
      check_output("hold_rvalid_a", rvalid_a, 1'b0);
      check_output("hold_rvalid_b", rvalid_b, 1'b0);

      // A read issued alongside init_start must still complete during the clear.
      rclke = 1'b1; re = 1'b1; raddr = 8'h10; init_start = 1'b1;
      push_read(8'h10, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      rclke = 1'b0; re = 1'b0; init_start = 1'b0;
      measure_clear("reinit", 1'b1);
      apply_read(8'h00);
      apply_read(8'h03);
      apply_read(8'h10);
      apply_read(8'hC7);
      apply_read(8'hFF);
      repeat (3) @(negedge clk);

      apply_write(8'h05, 16'h7777, 16'h0000);
      apply_read(8'h05);
      repeat (3) @(negedge clk);
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("midclr_rdata_a", rdata_a, 16'h0);
      check_output("midclr_rdata_b", rdata_b, 16'h0);
      check_output("midclr_rvalid_a", rvalid_a, 1'b0);
      check_output("midclr_rvalid_b", rvalid_b, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      measure_clear("rerst", 1'b0);
      apply_read(8'h05);
      apply_read(8'hFF);
      repeat (4) @(negedge clk);

      check_output("a_queue_drained", q_a.size(), 0);
      check_output("b_queue_drained", q_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
